// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM state encoding, legal
// parameter ranges and the parity helper used by uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_DATA_BITS_MIN = 5;
  localparam int UART_DATA_BITS_MAX = 8;
  localparam int UART_STOP_BITS_MIN = 1;
  localparam int UART_STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

  // Zero-padded inputs do not change the XOR, so narrow payloads pass through safely.
  function automatic logic calc_parity(input logic [UART_DATA_BITS_MAX-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start bit + DATA_BITS LSB-first + optional parity + STOP_BITS.
// Build option: define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_tx;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_data_last;
  logic                 w_stop_last;

`ifdef UART_TX_PARITY_EN
  logic r_parity;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  assign w_accept    = tx_valid && (r_state == ST_IDLE);
  assign w_data_last = (r_cnt == DATA_LAST);
  assign w_stop_last = (r_cnt == STOP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (tx_valid)  w_state_next = ST_SYNC;
      ST_SYNC:   if (baud_tick) w_state_next = ST_START;
      ST_START:  if (baud_tick) w_state_next = ST_DATA;
      ST_DATA: begin
        if (baud_tick && w_data_last) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_tick) w_state_next = ST_STOP;
`endif
      ST_STOP:   if (baud_tick && w_stop_last) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (r_state == ST_IDLE);
    tx_busy  = (r_state != ST_IDLE);
    tx       = r_tx;
    tx_done  = r_done;
  end

  // Accept only happens in IDLE, where baud_tick is ignored, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
      r_shift  <= '0;
      r_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift  <= tx_data;
        r_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity <= calc_parity(UART_DATA_BITS_MAX'(tx_data), PARITY_ODD);
`endif
      end else if (baud_tick) begin
        case (r_state)
          ST_SYNC: r_tx <= 1'b0;
          ST_START: begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          ST_DATA: begin
            if (w_data_last) begin
`ifdef UART_TX_PARITY_EN
              r_tx <= r_parity;
`else
              r_tx <= 1'b1;
`endif
              r_cnt <= '0;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: r_tx <= 1'b1;
`endif
          ST_STOP: begin
            if (w_stop_last) r_done <= 1'b1;
            else             r_cnt  <= r_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (1 and 2 stop bits), line monitors and a frame scoreboard.
// Honours UART_TX_PARITY_EN so expected frames match the build under test.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB0  = 1 + 8 + PAR + 1;
  localparam int NB1  = 1 + 8 + PAR + 2;
  localparam int TICK = 4;

  typedef struct {
    logic [15:0] bits;
    bit          stable;
    logic        done;
    int          start_cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] data0, data1;
  logic [1:0] valid_v, ready_v, line_v, busy_v, done_v;

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt [2] = '{0, 0};
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  obs_t        obs_q0 [$];
  obs_t        obs_q1 [$];

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data0), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(line_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data1), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(line_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  initial forever #5 clk = ~clk;

  // One-cycle baud strobe every TICK clocks.
  initial forever begin
    repeat (TICK - 1) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done_v[0] === 1'b1) done_cnt[0] = done_cnt[0] + 1;
    if (done_v[1] === 1'b1) done_cnt[1] = done_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] make_frame(input logic [7:0] d);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Captures each frame: every bit must hold TICK samples; tx_done is sampled right after.
  task automatic monitor(input int d, input int nb);
    obs_t o;
    bit   ab;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || line_v[d] !== 1'b0) continue;
      o.bits = '1; o.stable = 1'b1; o.start_cyc = cyc; o.done = 1'b0; ab = 1'b0;
      for (int i = 0; i < nb && !ab; i++) begin
        for (int k = 0; k < TICK; k++) begin
          if (i != 0 || k != 0) @(negedge clk);
          if (rst !== 1'b0) begin ab = 1'b1; break; end
          if (k == 0) o.bits[i] = line_v[d];
          else if (line_v[d] !== o.bits[i]) o.stable = 1'b0;
        end
      end
      if (ab) continue;
      @(negedge clk);
      o.done = done_v[d];
      if (d == 0) obs_q0.push_back(o);
      else        obs_q1.push_back(o);
    end
  endtask

  initial monitor(0, NB0);
  initial monitor(1, NB1);

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input int d, input logic [7:0] data, input string tag);
    int n;
    n = 0;
    while (ready_v[d] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk({tag, " ready wait"}, 32'(n < 200), 32'd1);
    if (d == 0) data0 = data; else data1 = data;
    valid_v[d] = 1'b1;
    @(negedge clk);
    valid_v[d] = 1'b0;
    if (d == 0) exp_q0.push_back(make_frame(data));
    else        exp_q1.push_back(make_frame(data));
  endtask

  task automatic expect_frame(input int d, input string tag, output obs_t o);
    logic [15:0] e;
    int n;
    n = 0;
    o.bits = '0; o.stable = 1'b0; o.done = 1'b0; o.start_cyc = 0;
    while (((d == 0) ? obs_q0.size() : obs_q1.size()) == 0 && n < 600) begin
      @(negedge clk); n++;
    end
    chk({tag, " frame timeout"}, 32'(n < 600), 32'd1);
    if (n >= 600) return;
    o = (d == 0) ? obs_q0.pop_front() : obs_q1.pop_front();
    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    chk({tag, " bits"}, 32'(o.bits), 32'(e));
    chk({tag, " bit width"}, 32'(o.stable), 32'd1);
    chk({tag, " done pulse"}, 32'(o.done), 32'd1);
    $display("[TB] dut%0d %s frame 0x%04h expected 0x%04h start_cyc %0d", d, tag, o.bits, e, o.start_cyc);
  endtask

  initial begin
    obs_t        o1, o2;
    int          n, base;
    logic [10:0] lit55;
    data0 = '0; data1 = '0; valid_v = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset tx0", 32'(line_v[0]), 32'd1);
    chk("reset ready0", 32'(ready_v[0]), 32'd1);
    chk("reset busy0", 32'(busy_v[0]), 32'd0);
    chk("reset done0", 32'(done_v[0]), 32'd0);
    chk("reset tx1", 32'(line_v[1]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 0x55.
    base = done_cnt[0];
    send(0, 8'h55, "tx55");
    chk("tx55 ready drop", 32'(ready_v[0]), 32'd0);
    chk("tx55 busy", 32'(busy_v[0]), 32'd1);
    expect_frame(0, "tx55", o1);
`ifdef UART_TX_PARITY_EN
    lit55 = 11'h4AA;
`else
    lit55 = 11'h6AA;
`endif
    chk("tx55 line sequence", 32'(o1.bits[10:0]), 32'(lit55));
    @(negedge clk);
    chk("tx55 done count", 32'(done_cnt[0] - base), 32'd1);

    // Parity position carries parity when compiled in, otherwise the stop bit.
    send(0, 8'h07, "tx07");
    expect_frame(0, "tx07", o1);
    chk("tx07 bit9", 32'(o1.bits[9]), 32'd1);
    send(0, 8'hA5, "txA5");
    expect_frame(0, "txA5", o1);
`ifdef UART_TX_PARITY_EN
    chk("txA5 parity", 32'(o1.bits[9]), 32'd0);
`else
    chk("txA5 stop", 32'(o1.bits[9]), 32'd1);
`endif

    // Back-to-back with tx_valid held.
    @(negedge clk);
    base = done_cnt[0];
    data0 = 8'h0F; valid_v[0] = 1'b1;
    @(negedge clk);
    chk("b2b first accept", 32'(ready_v[0]), 32'd0);
    exp_q0.push_back(make_frame(8'h0F));
    data0 = 8'hF0;
    n = 0;
    while (ready_v[0] !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk("b2b ready return", 32'(n < 600), 32'd1);
    chk("b2b ready with done", 32'(done_v[0]), 32'd1);
    @(negedge clk);
    chk("b2b immediate accept", 32'(ready_v[0]), 32'd0);
    valid_v[0] = 1'b0;
    exp_q0.push_back(make_frame(8'hF0));
    expect_frame(0, "b2b0F", o1);
    expect_frame(0, "b2bF0", o2);
    chk("b2b start spacing", 32'(o2.start_cyc - o1.start_cyc), 32'(TICK * (NB0 + 1)));
    @(negedge clk);
    chk("b2b done count", 32'(done_cnt[0] - base), 32'd2);

    // Busy drop: 0xFF offered mid-frame must vanish.
    base = done_cnt[0];
    send(0, 8'h00, "drop00");
    repeat (14) @(negedge clk);
    chk("drop busy", 32'(ready_v[0]), 32'd0);
    data0 = 8'hFF; valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    expect_frame(0, "drop00", o1);
    repeat (40) @(negedge clk);
    chk("drop no extra frame", 32'(obs_q0.size()), 32'd0);
    chk("drop line idle", 32'(line_v[0]), 32'd1);
    chk("drop done count", 32'(done_cnt[0] - base), 32'd1);

    // Reset in data bit 3.
    base = done_cnt[0];
    send(0, 8'h22, "abort22");
    n = 0;
    while (line_v[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("abort start seen", 32'(n < 100), 32'd1);
    repeat (17) @(negedge clk);
    chk("abort bit3 low", 32'(line_v[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort tx high", 32'(line_v[0]), 32'd1);
    chk("abort ready", 32'(ready_v[0]), 32'd1);
    chk("abort busy", 32'(busy_v[0]), 32'd0);
    chk("abort done", 32'(done_v[0]), 32'd0);
    void'(exp_q0.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(0, 8'hC3, "postrst");
    chk("postrst first edge accept", 32'(ready_v[0]), 32'd0);
    expect_frame(0, "postrst", o1);
    @(negedge clk);
    chk("abort done count", 32'(done_cnt[0] - base), 32'd1);

    // Two stop bits.
    base = done_cnt[1];
    send(1, 8'h3C, "stop2");
    expect_frame(1, "stop2", o1);
    chk("stop2 stop bits", 32'(o1.bits[NB1-1 -: 2]), 32'd3);
    chk("stop2 last data", 32'(o1.bits[8]), 32'd0);
    @(negedge clk);
    chk("stop2 done count", 32'(done_cnt[1] - base), 32'd1);

    chk("scoreboard0 empty", 32'(exp_q0.size()), 32'd0);
    chk("scoreboard1 empty", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
